// File: rtl/accel_axis_conditioner.sv
// Per-channel accelerometer conditioning: moving average, peak-magnitude tracking and
// latest sample. One selected channel is published in sign/magnitude form at a paced tick.
module accel_axis_conditioner #(
  parameter int DATA_W     = 16,
  parameter int N_CH       = 3,
  parameter int SEL_W      = 2,
  parameter int AVG_LOG2   = 2,
  parameter int UPDATE_DIV = 500000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data_update,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]       sel,
  input  logic [1:0]             mode,
  input  logic                   hold,
  input  logic                   clear_peak,
  output logic [DATA_W-1:0]      out_mag,
  output logic                   out_neg,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  typedef struct packed {
    logic              neg;
    logic [DATA_W-1:0] mag;
  } sm_t;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'b00,
    MODE_PEAK = 2'b01,
    MODE_RAW  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam sample_t MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_MAG = {1'b0, {(DATA_W-1){1'b1}}};

  // Most-negative input saturates so the magnitude always fits in DATA_W bits.
  function automatic sm_t to_sm(input sample_t x);
    sm_t r;
    r.neg = x[DATA_W-1];
    if (x == MOST_NEG)
      r.mag = MAX_MAG;
    else if (x[DATA_W-1])
      r.mag = DATA_W'(-x);
    else
      r.mag = DATA_W'(x);
    return r;
  endfunction

  function automatic sum_t sext(input sample_t x);
    return {{AVG_LOG2{x[DATA_W-1]}}, x};
  endfunction

  sample_t              hist     [N_CH][DEPTH];
  sum_t                 sum_q    [N_CH];
  sample_t              latest_q [N_CH];
  sm_t                  peak_q   [N_CH];
  logic [AVG_LOG2-1:0]  wp;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;

  sample_t              new_s    [N_CH];
  sm_t                  new_sm   [N_CH];
  sum_t                 sum_nxt  [N_CH];
  sample_t              avg      [N_CH];
  sum_t                 avg_full [N_CH];
  sm_t                  pub;

  assign tick = (cnt == CNT_W'(UPDATE_DIV - 1));

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      new_s[c]    = data_in[c*DATA_W +: DATA_W];
      new_sm[c]   = to_sm(new_s[c]);
      sum_nxt[c]  = sum_q[c] - sext(hist[c][wp]) + sext(new_s[c]);
      avg_full[c] = sum_q[c] >>> AVG_LOG2;
      avg[c]      = avg_full[c][DATA_W-1:0];
    end
  end

  // Selection works on registered state only, so a same-cycle sample is never published.
  always_comb begin
    pub = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == SEL_W'(c)) begin
        case (mode_e'(mode))
          MODE_AVG:  pub = to_sm(avg[c]);
          MODE_PEAK: pub = peak_q[c];
          default:   pub = to_sm(latest_q[c]);
        endcase
      end
    end
  end

  // NOTE: the history is reset on purpose; the average ramp after reset depends on
  // the buffer starting at zero, so this memory cannot be left uninitialised.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      for (int c = 0; c < N_CH; c++) begin
        sum_q[c]    <= '0;
        latest_q[c] <= '0;
        peak_q[c]   <= '0;
        for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
      end
    end else begin
      if (data_update) begin
        wp <= wp + 1'b1;
        for (int c = 0; c < N_CH; c++) begin
          sum_q[c]     <= sum_nxt[c];
          hist[c][wp]  <= new_s[c];
          latest_q[c]  <= new_s[c];
          if (clear_peak || (new_sm[c].mag > peak_q[c].mag))
            peak_q[c] <= new_sm[c];
        end
      end else if (clear_peak) begin
        for (int c = 0; c < N_CH; c++) peak_q[c] <= '0;
      end
    end
  end

  // NOTE: all state registers use non-blocking assignments so every block sees
  // the pre-edge values, which is what makes the tick/update collision well defined.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      out_mag   <= '0;
      out_neg   <= 1'b0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      out_valid <= 1'b0;
      if (tick && !hold) begin
        out_mag   <= pub.mag;
        out_neg   <= pub.neg;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_axis_conditioner.sv
// Directed bench for accel_axis_conditioner with a 4-cycle display tick.
module tb_accel_axis_conditioner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        data_update;
  logic [47:0] data_in;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic        hold;
  logic        clear_peak;
  logic [15:0] out_mag;
  logic        out_neg;
  logic [1:0]  out_ch;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accel_axis_conditioner #(
    .DATA_W(16), .N_CH(3), .SEL_W(2), .AVG_LOG2(2), .UPDATE_DIV(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_update(data_update), .data_in(data_in),
    .sel(sel), .mode(mode), .hold(hold), .clear_peak(clear_peak),
    .out_mag(out_mag), .out_neg(out_neg), .out_ch(out_ch), .out_valid(out_valid)
  );

  task automatic do_reset();
    reset_n = 1'b0; data_update = 1'b0; clear_peak = 1'b0; hold = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One strobe cycle; other channels carry zero.
  task automatic drive(input int ch, input logic signed [15:0] v, input logic upd, input logic cp);
    data_in = '0;
    data_in[ch*16 +: 16] = v;
    data_update = upd;
    clear_peak = cp;
    @(negedge clk);
    data_update = 1'b0;
    clear_peak = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: out_valid actual=0 required=1 within 16 cycles", tag);
    end
  endtask

  task automatic test_reset();
    sel = 2'd0; mode = 2'b10;
    reset_n = 1'b0; hold = 1'b0; clear_peak = 1'b0;
    data_in = 48'd1000; data_update = 1'b1;
    repeat (2) @(negedge clk);
    data_update = 1'b0;
    checks++;
    if ({out_mag, out_neg, out_ch, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: actual mag=%0d neg=%0b ch=%0d valid=%0b required all 0",
               out_mag, out_neg, out_ch, out_valid);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL reset_pulse cycle %0d: out_valid actual=%0b required=%0b",
                 i, out_valid, (i % 4) == 0);
      end
      checks++;
      if (out_mag !== 16'd0 || out_neg !== 1'b0) begin
        errors++;
        $display("FAIL reset_drop cycle %0d: mag=%0d neg=%0b required 0/0", i, out_mag, out_neg);
      end
    end
  endtask

  task automatic test_average();
    int vals [5] = '{100, 100, 100, 100, -100};
    int exps [5] = '{25, 50, 75, 100, 50};
    do_reset();
    sel = 2'd0; mode = 2'b00;
    wait_valid("avg_sync");
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'(vals[i]), 1'b1, 1'b0);
      wait_valid("avg");
      checks++;
      if (out_mag !== 16'(exps[i]) || out_neg !== 1'b0 || out_ch !== 2'd0) begin
        errors++;
        $display("FAIL avg step %0d: mag=%0d neg=%0b ch=%0d required mag=%0d neg=0 ch=0",
                 i, out_mag, out_neg, out_ch, exps[i]);
      end
    end
  endtask

  task automatic test_sign();
    do_reset();
    sel = 2'd1; mode = 2'b10;
    wait_valid("sign_sync");
    drive(1, 16'h8000, 1'b1, 1'b0);
    wait_valid("sign_sat");
    checks++;
    if (out_mag !== 16'h7FFF || out_neg !== 1'b1 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL sign_sat: mag=%h neg=%0b ch=%0d required mag=7fff neg=1 ch=1", out_mag, out_neg, out_ch);
    end
    drive(1, -16'sd5, 1'b1, 1'b0);
    wait_valid("sign_neg5");
    checks++;
    if (out_mag !== 16'd5 || out_neg !== 1'b1) begin
      errors++;
      $display("FAIL sign_neg5: mag=%0d neg=%0b required mag=5 neg=1", out_mag, out_neg);
    end
    mode = 2'b11;
    wait_valid("sign_rsvd");
    checks++;
    if (out_mag !== 16'd5 || out_neg !== 1'b1) begin
      errors++;
      $display("FAIL mode_reserved: mag=%0d neg=%0b required mag=5 neg=1", out_mag, out_neg);
    end
    // sum = -32768 - 5 = -32773; arithmetic shift by 2 floors to -8194.
    mode = 2'b00;
    wait_valid("sign_avg");
    checks++;
    if (out_mag !== 16'd8194 || out_neg !== 1'b1) begin
      errors++;
      $display("FAIL neg_avg: mag=%0d neg=%0b required mag=8194 neg=1", out_mag, out_neg);
    end
  endtask

  task automatic test_peak();
    int   vals [5] = '{10, -300, 300, 20, 7};
    logic cps  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   mags [5] = '{10, 300, 300, 300, 7};
    logic negs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    sel = 2'd2; mode = 2'b01;
    wait_valid("peak_sync");
    for (int i = 0; i < 5; i++) begin
      drive(2, 16'(vals[i]), 1'b1, cps[i]);
      wait_valid("peak");
      checks++;
      if (out_mag !== 16'(mags[i]) || out_neg !== negs[i] || out_ch !== 2'd2) begin
        errors++;
        $display("FAIL peak step %0d: mag=%0d neg=%0b ch=%0d required mag=%0d neg=%0b ch=2",
                 i, out_mag, out_neg, out_ch, mags[i], negs[i]);
      end
    end
    drive(2, 16'd0, 1'b0, 1'b1);
    wait_valid("peak_clear");
    checks++;
    if (out_mag !== 16'd0 || out_neg !== 1'b0) begin
      errors++;
      $display("FAIL peak_clear: mag=%0d neg=%0b required mag=0 neg=0", out_mag, out_neg);
    end
  endtask

  task automatic test_hold_select();
    do_reset();
    sel = 2'd2; mode = 2'b10;
    wait_valid("hold_sync");
    drive(2, 16'd42, 1'b1, 1'b0);
    wait_valid("hold_pre");
    checks++;
    if (out_mag !== 16'd42) begin
      errors++;
      $display("FAIL hold_pre: mag=%0d required 42", out_mag);
    end
    hold = 1'b1;
    drive(2, 16'd99, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_mag !== 16'd42) begin
        errors++;
        $display("FAIL hold cycle %0d: valid=%0b mag=%0d required valid=0 mag=42", i, out_valid, out_mag);
      end
    end
    hold = 1'b0;
    wait_valid("hold_release");
    checks++;
    if (out_mag !== 16'd99) begin
      errors++;
      $display("FAIL hold_release: mag=%0d required 99", out_mag);
    end
    sel = 2'd3;
    wait_valid("sel_oob");
    checks++;
    if (out_mag !== 16'd0 || out_neg !== 1'b0 || out_ch !== 2'd3) begin
      errors++;
      $display("FAIL sel_oob: mag=%0d neg=%0b ch=%0d required mag=0 neg=0 ch=3", out_mag, out_neg, out_ch);
    end
  endtask

  task automatic test_collision_reset();
    do_reset();
    sel = 2'd1; mode = 2'b10;
    wait_valid("coll_sync");
    drive(1, 16'd11, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    drive(1, 16'd500, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_mag !== 16'd11) begin
      errors++;
      $display("FAIL collision: valid=%0b mag=%0d required valid=1 mag=11", out_valid, out_mag);
    end
    wait_valid("coll_next");
    checks++;
    if (out_mag !== 16'd500 || out_ch !== 2'd1) begin
      errors++;
      $display("FAIL collision_next: mag=%0d ch=%0d required mag=500 ch=1", out_mag, out_ch);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_mag, out_neg, out_ch, out_valid} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: mag=%0d neg=%0b ch=%0d valid=%0b required all 0",
               out_mag, out_neg, out_ch, out_valid);
    end
    reset_n = 1'b1;
    sel = 2'd0; mode = 2'b00;
    wait_valid("ramp_sync");
    drive(0, 16'd40, 1'b1, 1'b0);
    wait_valid("ramp_restart");
    checks++;
    if (out_mag !== 16'd10 || out_neg !== 1'b0) begin
      errors++;
      $display("FAIL ramp_restart: mag=%0d neg=%0b required mag=10 neg=0", out_mag, out_neg);
    end
  endtask

  initial begin
    reset_n = 1'b0; data_update = 1'b0; data_in = '0;
    sel = '0; mode = '0; hold = 1'b0; clear_peak = 1'b0;
    @(negedge clk);
    test_reset();
    test_average();
    test_sign();
    test_peak();
    test_hold_select();
    test_collision_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
